// File: rtl/ct_cp0_rst_inv_pkg.sv
// Shared types and constants for the CP0 reset-invalidate responder.
// Array depths and walk target slots used by the controller and the walker.
package ct_cp0_rst_inv_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StWalk = 3'b010,
        StDone = 3'b100
    } rst_inv_st_e;

    localparam int unsigned ICACHE_DEPTH = 512;
    localparam int unsigned BHT_DEPTH    = 1024;

    localparam int unsigned NUM_TGT    = 2;
    localparam int unsigned TGT_ICACHE = 0;
    localparam int unsigned TGT_BHT    = 1;

endpackage

// File: rtl/ct_cp0_inv_walker.sv
// Shared index walker: one counter drives several invalidate targets in lock-step,
// with per-target pending and granted-this-index bookkeeping.
module ct_cp0_inv_walker #(
    parameter int unsigned NumTgt = 2,
    parameter int unsigned CntW   = 10
) (
    input  logic                           vec_sm_clk,
    input  logic                           cpurst_b,
    input  logic                           start,
    input  logic                           active,
    input  logic [NumTgt-1:0][CntW-1:0]    last_idx,
    input  logic [NumTgt-1:0]              grant,
    output logic [NumTgt-1:0]              vld,
    output logic [CntW-1:0]                cnt,
    output logic                           finish
);

    logic [NumTgt-1:0] pend_q, pend_d;
    logic [NumTgt-1:0] gnt_q, gnt_d;
    logic [NumTgt-1:0] ok;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              adv;

    always_comb begin
        vld    = '0;
        ok     = '0;
        pend_d = pend_q;
        gnt_d  = gnt_q;
        cnt_d  = cnt_q;
        // A target already granted for this index, or no longer pending, never stalls the walk.
        for (int i = 0; i < NumTgt; i++) begin
            vld[i] = active & pend_q[i] & ~gnt_q[i];
            ok[i]  = ~pend_q[i] | gnt_q[i] | grant[i];
        end
        adv = active & (&ok);
        if (start) begin
            pend_d = '1;
            gnt_d  = '0;
            cnt_d  = '0;
        end else if (adv) begin
            gnt_d = '0;
            cnt_d = cnt_q + CntW'(1);
            for (int i = 0; i < NumTgt; i++) begin
                if (cnt_q == last_idx[i]) begin
                    pend_d[i] = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < NumTgt; i++) begin
                gnt_d[i] = gnt_q[i] | (vld[i] & grant[i]);
            end
        end
        finish = active & ~(|pend_d);
        if (finish) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge vec_sm_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            pend_q <= '0;
            gnt_q  <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            gnt_q  <= gnt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ct_cp0_rst_inv_ctrl.sv
// Responder end of the IFU reset-invalidate handshake: walks every icache set and
// BHT entry after a start pulse, then holds a sticky done level for the vector FSM.
module ct_cp0_rst_inv_ctrl
    import ct_cp0_rst_inv_pkg::*;
#(
    parameter int unsigned ICACHE_IDX_W = 9,
    parameter int unsigned BHT_IDX_W    = 10,
    parameter int unsigned WALK_W       = 10
) (
    input  logic                    vec_sm_clk,
    input  logic                    cpurst_b,
    input  logic                    ifu_cp0_rst_inv_req,
    input  logic                    pad_yy_rst_inv_skip,
    output logic                    cp0_icache_inv_vld,
    output logic [ICACHE_IDX_W-1:0] cp0_icache_inv_idx,
    input  logic                    icache_cp0_inv_grant,
    output logic                    cp0_bht_inv_vld,
    output logic [BHT_IDX_W-1:0]    cp0_bht_inv_idx,
    input  logic                    bht_cp0_inv_grant,
    output logic                    cp0_ifu_rst_inv_done,
    output logic                    cp0_rst_inv_busy,
    output logic [2:0]              cp0_rst_inv_cur_st
);

    rst_inv_st_e                       state_q;
    logic                              start;
    logic                              finish;
    logic [NUM_TGT-1:0]                vld;
    logic [NUM_TGT-1:0]                grant;
    logic [NUM_TGT-1:0][WALK_W-1:0]    last_idx;
    logic [WALK_W-1:0]                 cnt;

    // Requests arriving mid-walk are dropped; only IDLE or DONE may restart.
    assign start = ifu_cp0_rst_inv_req & ~pad_yy_rst_inv_skip & (state_q != StWalk);

    assign grant[TGT_ICACHE]    = icache_cp0_inv_grant;
    assign grant[TGT_BHT]       = bht_cp0_inv_grant;
    assign last_idx[TGT_ICACHE] = WALK_W'(ICACHE_DEPTH - 1);
    assign last_idx[TGT_BHT]    = WALK_W'(BHT_DEPTH - 1);

    ct_cp0_inv_walker #(
        .NumTgt (NUM_TGT),
        .CntW   (WALK_W)
    ) u_walker (
        .vec_sm_clk (vec_sm_clk),
        .cpurst_b   (cpurst_b),
        .start      (start),
        .active     (state_q == StWalk),
        .last_idx   (last_idx),
        .grant      (grant),
        .vld        (vld),
        .cnt        (cnt),
        .finish     (finish)
    );

    always_ff @(posedge vec_sm_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (ifu_cp0_rst_inv_req) begin
                        state_q <= pad_yy_rst_inv_skip ? StDone : StWalk;
                    end
                end
                StWalk: begin
                    if (finish) begin
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cp0_icache_inv_vld   = vld[TGT_ICACHE];
    assign cp0_icache_inv_idx   = cnt[ICACHE_IDX_W-1:0];
    assign cp0_bht_inv_vld      = vld[TGT_BHT];
    assign cp0_bht_inv_idx      = cnt[BHT_IDX_W-1:0];
    assign cp0_ifu_rst_inv_done = (state_q == StDone);
    assign cp0_rst_inv_busy     = (state_q == StWalk);
    assign cp0_rst_inv_cur_st   = state_q;

endmodule

// File: tb/tb_ct_cp0_rst_inv_ctrl.sv
// Scoreboard bench for the reset-invalidate responder: expected indices are queued
// on each request and consumed as the DUT issues granted invalidates.
module tb_ct_cp0_rst_inv_ctrl;

    logic       vec_sm_clk = 1'b0;
    logic       cpurst_b = 1'b1;
    logic       ifu_cp0_rst_inv_req = 1'b0;
    logic       pad_yy_rst_inv_skip = 1'b0;
    logic       icache_cp0_inv_grant = 1'b1;
    logic       bht_cp0_inv_grant = 1'b1;
    logic       cp0_icache_inv_vld;
    logic [8:0] cp0_icache_inv_idx;
    logic       cp0_bht_inv_vld;
    logic [9:0] cp0_bht_inv_idx;
    logic       cp0_ifu_rst_inv_done;
    logic       cp0_rst_inv_busy;
    logic [2:0] cp0_rst_inv_cur_st;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ic_q[$];
    int bht_q[$];
    int ic_last = 0;
    int bht_last = 0;

    ct_cp0_rst_inv_ctrl dut (
        .vec_sm_clk           (vec_sm_clk),
        .cpurst_b             (cpurst_b),
        .ifu_cp0_rst_inv_req  (ifu_cp0_rst_inv_req),
        .pad_yy_rst_inv_skip  (pad_yy_rst_inv_skip),
        .cp0_icache_inv_vld   (cp0_icache_inv_vld),
        .cp0_icache_inv_idx   (cp0_icache_inv_idx),
        .icache_cp0_inv_grant (icache_cp0_inv_grant),
        .cp0_bht_inv_vld      (cp0_bht_inv_vld),
        .cp0_bht_inv_idx      (cp0_bht_inv_idx),
        .bht_cp0_inv_grant    (bht_cp0_inv_grant),
        .cp0_ifu_rst_inv_done (cp0_ifu_rst_inv_done),
        .cp0_rst_inv_busy     (cp0_rst_inv_busy),
        .cp0_rst_inv_cur_st   (cp0_rst_inv_cur_st)
    );

    always #5 vec_sm_clk = ~vec_sm_clk;
    always @(posedge vec_sm_clk) cyc <= cyc + 1;

    // Scoreboard consumer: every granted invalidate must match the next queued index.
    always @(negedge vec_sm_clk) begin
        int e;
        if (cpurst_b) begin
            if (cp0_icache_inv_vld && icache_cp0_inv_grant) begin
                checks++;
                if (ic_q.size() == 0) begin
                    errors++;
                    $display("FAIL icache_extra issued idx %0d, none expected", cp0_icache_inv_idx);
                end else begin
                    e = ic_q.pop_front();
                    if (int'(cp0_icache_inv_idx) != e) begin
                        errors++;
                        $display("FAIL icache_idx got %0d expected %0d", cp0_icache_inv_idx, e);
                    end
                end
                ic_last = cyc;
            end
            if (cp0_bht_inv_vld && bht_cp0_inv_grant) begin
                checks++;
                if (bht_q.size() == 0) begin
                    errors++;
                    $display("FAIL bht_extra issued idx %0d, none expected", cp0_bht_inv_idx);
                end else begin
                    e = bht_q.pop_front();
                    if (int'(cp0_bht_inv_idx) != e) begin
                        errors++;
                        $display("FAIL bht_idx got %0d expected %0d", cp0_bht_inv_idx, e);
                    end
                end
                bht_last = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge vec_sm_clk);
        #1;
    endtask

    task automatic pulse_req(input bit push, output int rcyc);
        ifu_cp0_rst_inv_req = 1'b1;
        rcyc = cyc;
        if (push) begin
            for (int i = 0; i < 512; i++) ic_q.push_back(i);
            for (int i = 0; i < 1024; i++) bht_q.push_back(i);
        end
        tick();
        ifu_cp0_rst_inv_req = 1'b0;
    endtask

    // Returns cycles from request to done, or -1 if done never arrives.
    task automatic wait_done(input int rcyc, output int lat);
        int n = 0;
        while (!cp0_ifu_rst_inv_done && n < 3000) begin
            tick();
            n++;
        end
        lat = cp0_ifu_rst_inv_done ? (cyc - rcyc) : -1;
    endtask

    task automatic test_reset();
        #1 cpurst_b = 1'b0;
        #1;
        checks++;
        if ({cp0_icache_inv_vld, cp0_icache_inv_idx, cp0_bht_inv_vld, cp0_bht_inv_idx,
             cp0_ifu_rst_inv_done, cp0_rst_inv_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero vld/idx/done/busy, expected all 0");
        end
        checks++;
        if (cp0_rst_inv_cur_st !== 3'b001) begin
            errors++;
            $display("FAIL reset_state got %b expected 001", cp0_rst_inv_cur_st);
        end
        tick();
        tick();
        cpurst_b = 1'b1;
    endtask

    task automatic test_baseline();
        int r, lat;
        while (cyc < 10) tick();
        pulse_req(1'b1, r);
        checks++;
        if (cp0_rst_inv_cur_st !== 3'b010 || cp0_rst_inv_busy !== 1'b1) begin
            errors++;
            $display("FAIL walk_entry got st %b busy %b expected 010 1",
                     cp0_rst_inv_cur_st, cp0_rst_inv_busy);
        end
        wait_done(r, lat);
        checks++;
        if (lat != 1025) begin
            errors++;
            $display("FAIL base_latency got %0d expected 1025", lat);
        end
        checks++;
        if (ic_last - r != 512 || bht_last - r != 1024) begin
            errors++;
            $display("FAIL base_last_issue got ic %0d bht %0d expected 512 1024",
                     ic_last - r, bht_last - r);
        end
        checks++;
        if (ic_q.size() != 0 || bht_q.size() != 0) begin
            errors++;
            $display("FAIL base_missing got %0d/%0d left expected 0/0", ic_q.size(), bht_q.size());
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (cp0_ifu_rst_inv_done !== 1'b1 || cp0_rst_inv_busy !== 1'b0 ||
            cp0_rst_inv_cur_st !== 3'b100) begin
            errors++;
            $display("FAIL done_hold got done %b busy %b st %b expected 1 0 100",
                     cp0_ifu_rst_inv_done, cp0_rst_inv_busy, cp0_rst_inv_cur_st);
        end
    endtask

    task automatic test_rerun_from_done();
        int r, lat;
        pulse_req(1'b1, r);
        checks++;
        if (cp0_ifu_rst_inv_done !== 1'b0 || cp0_rst_inv_busy !== 1'b1) begin
            errors++;
            $display("FAIL rerun_clear got done %b busy %b expected 0 1",
                     cp0_ifu_rst_inv_done, cp0_rst_inv_busy);
        end
        wait_done(r, lat);
        checks++;
        if (lat != 1025 || ic_q.size() != 0 || bht_q.size() != 0) begin
            errors++;
            $display("FAIL rerun_latency got %0d (left %0d/%0d) expected 1025 (0/0)",
                     lat, ic_q.size(), bht_q.size());
        end
    endtask

    task automatic test_stall();
        int r, lat, n, bad;
        pulse_req(1'b1, r);
        n = 0;
        while (!(cp0_icache_inv_vld && cp0_icache_inv_idx == 9'd100) && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (!(cp0_icache_inv_vld && cp0_icache_inv_idx == 9'd100)) begin
            errors++;
            $display("FAIL stall_reach got idx %0d expected 100", cp0_icache_inv_idx);
        end
        icache_cp0_inv_grant = 1'b0;
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k < 20 && (cp0_bht_inv_vld !== 1'b0 || cp0_icache_inv_vld !== 1'b1 ||
                           cp0_icache_inv_idx !== 9'd100 || cp0_bht_inv_idx !== 10'd100))
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold got %0d unstable cycles expected 0", bad);
        end
        icache_cp0_inv_grant = 1'b1;
        wait_done(r, lat);
        checks++;
        if (lat != 1045 || ic_q.size() != 0 || bht_q.size() != 0) begin
            errors++;
            $display("FAIL stall_latency got %0d (left %0d/%0d) expected 1045 (0/0)",
                     lat, ic_q.size(), bht_q.size());
        end
    endtask

    task automatic test_midwalk_req();
        int r, r2, lat, n, bad;
        pulse_req(1'b1, r);
        n = 0;
        while (!(cp0_bht_inv_vld && cp0_bht_inv_idx == 10'd300) && n < 2000) begin
            tick();
            n++;
        end
        pulse_req(1'b0, r2);
        tick();
        pulse_req(1'b0, r2);
        checks++;
        if (cp0_rst_inv_busy !== 1'b1 || cp0_bht_inv_idx !== 10'd303) begin
            errors++;
            $display("FAIL midreq_ignored got busy %b idx %0d expected 1 303",
                     cp0_rst_inv_busy, cp0_bht_inv_idx);
        end
        wait_done(r, lat);
        checks++;
        if (lat != 1025 || ic_q.size() != 0 || bht_q.size() != 0) begin
            errors++;
            $display("FAIL midreq_latency got %0d (left %0d/%0d) expected 1025 (0/0)",
                     lat, ic_q.size(), bht_q.size());
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cp0_ifu_rst_inv_done !== 1'b1 || cp0_rst_inv_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreq_single_done got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_reset_midwalk();
        int r, lat, n;
        pulse_req(1'b1, r);
        n = 0;
        while (!(cp0_bht_inv_vld && cp0_bht_inv_idx == 10'd700) && n < 2000) begin
            tick();
            n++;
        end
        cpurst_b = 1'b0;
        #1;
        checks++;
        if ({cp0_icache_inv_vld, cp0_icache_inv_idx, cp0_bht_inv_vld, cp0_bht_inv_idx,
             cp0_ifu_rst_inv_done, cp0_rst_inv_busy} !== '0 || cp0_rst_inv_cur_st !== 3'b001) begin
            errors++;
            $display("FAIL async_reset got bht idx %0d vld %b st %b expected 0 0 001",
                     cp0_bht_inv_idx, cp0_bht_inv_vld, cp0_rst_inv_cur_st);
        end
        ic_q.delete();
        bht_q.delete();
        tick();
        tick();
        cpurst_b = 1'b1;
        tick();
        pulse_req(1'b1, r);
        wait_done(r, lat);
        checks++;
        if (lat != 1025 || ic_q.size() != 0 || bht_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_latency got %0d (left %0d/%0d) expected 1025 (0/0)",
                     lat, ic_q.size(), bht_q.size());
        end
    endtask

    task automatic test_skip();
        int r, seen;
        cpurst_b = 1'b0;
        tick();
        cpurst_b = 1'b1;
        tick();
        pad_yy_rst_inv_skip = 1'b1;
        pulse_req(1'b0, r);
        checks++;
        if (cp0_ifu_rst_inv_done !== 1'b1 || cp0_rst_inv_busy !== 1'b0) begin
            errors++;
            $display("FAIL skip_done got done %b busy %b expected 1 0",
                     cp0_ifu_rst_inv_done, cp0_rst_inv_busy);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (cp0_icache_inv_vld || cp0_bht_inv_vld) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL skip_no_vld got %0d vld cycles expected 0", seen);
        end
        pad_yy_rst_inv_skip = 1'b0;
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_rerun_from_done();
        test_stall();
        test_midwalk_req();
        test_reset_midwalk();
        test_skip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
